dmem_arbiter: RTL



---
 rtl/dmem_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : CPU/DMA arbiter for the data-memory port with load-response steering.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter  int MAX_BURST = 4,
  localparam int XLEN      = 32,
  localparam int ALEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [3:0]      cpu_be,
  input  logic [2:0]      cpu_funct3,
  input  logic [ALEN-1:0] cpu_addr,
  input  logic [XLEN-1:0] cpu_wdata,
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [3:0]      dma_be,
  input  logic [2:0]      dma_funct3,
  input  logic [ALEN-1:0] dma_addr,
  input  logic [XLEN-1:0] dma_wdata,
  output logic            cpu_gnt,
  output logic            dma_gnt,
  output logic            cpu_rvalid,
  output logic            dma_rvalid,
  output logic [XLEN-1:0] cpu_rdata,
  output logic [XLEN-1:0] dma_rdata,
  output logic            mem_write,
  output logic [3:0]      mem_be,
  output logic [2:0]      mem_funct3,
  output logic [ALEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int            C_CW     = $clog2(MAX_BURST + 1);
  localparam logic [C_CW-1:0] C_MAX  = C_CW'(MAX_BURST);
  localparam logic [2:0]    C_F3_WORD = 3'b010;

  logic [C_CW-1:0] burst_cnt_q, burst_cnt_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_owner_q, resp_owner_d;
  logic            w_burst_full;

  assign w_burst_full = (burst_cnt_q == C_MAX);

  // DMA wins only when the CPU is absent or has used up its burst allowance.
  assign dma_gnt = ~rst & dma_req & (~cpu_req | w_burst_full);
  assign cpu_gnt = ~rst & cpu_req & ~dma_gnt;

  always_comb begin
    mem_write  = 1'b0;
    mem_be     = '0;
    mem_funct3 = C_F3_WORD;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (cpu_gnt) begin
      mem_write  = cpu_we;
      mem_be     = cpu_be;
      mem_funct3 = cpu_funct3;
      mem_addr   = cpu_addr;
      mem_wdata  = cpu_wdata;
    end else if (dma_gnt) begin
      mem_write  = dma_we;
      mem_be     = dma_be;
      mem_funct3 = dma_funct3;
      mem_addr   = dma_addr;
      mem_wdata  = dma_wdata;
    end
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (!dma_req || dma_gnt)
      burst_cnt_d = '0;
    else if (cpu_gnt && !w_burst_full)
      burst_cnt_d = burst_cnt_q + 1'b1;

    resp_valid_d = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
    resp_owner_d = resp_valid_d ? dma_gnt : resp_owner_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
    end else begin
      burst_cnt_q  <= burst_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  assign cpu_rvalid = resp_valid_q & ~resp_owner_q;
  assign dma_rvalid = resp_valid_q &  resp_owner_q;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule
`default_nettype wire
